// File: rtl/shifter_iter.sv
// Iterative dual-channel shifter/rotator: both operands are shifted by the same
// mode and amount, one bit position per clock, behind a start/busy/done handshake.
module shifter_iter #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       Modo,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [AMT_W-1:0] Cantidad,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Res_A,
    output logic [WIDTH-1:0] Res_B,
    output logic             C_A,
    output logic             C_B
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [2:0]       mode_r;
    logic [2:0]       mode_nxt_s;
    logic [AMT_W-1:0] cnt_r;
    logic [AMT_W-1:0] cnt_nxt_s;
    logic [WIDTH-1:0] res_a_nxt_s;
    logic [WIDTH-1:0] res_b_nxt_s;
    logic             c_a_nxt_s;
    logic             c_b_nxt_s;
    logic             busy_nxt_s;
    logic             done_nxt_s;
    logic [WIDTH:0]   step_a_s;
    logic [WIDTH:0]   step_b_s;

    // One 1-bit step; returns {carry, result}. Reserved modes keep both unchanged.
    function automatic logic [WIDTH:0] shift_step(
        input logic [2:0]       mode,
        input logic [WIDTH-1:0] r,
        input logic             c
    );
        logic [WIDTH:0] out;
        case (mode)
            3'b000:  out = {r[WIDTH-1], r[WIDTH-2:0], 1'b0};
            3'b001:  out = {r[0], 1'b0, r[WIDTH-1:1]};
            3'b010:  out = {r[0], r[WIDTH-1], r[WIDTH-1:1]};
            3'b011:  out = {r[WIDTH-1], r[WIDTH-2:0], r[WIDTH-1]};
            3'b100:  out = {r[0], r[0], r[WIDTH-1:1]};
            default: out = {c, r};
        endcase
        return out;
    endfunction

    // Next-state and next-datapath decode for the handshake FSM.
    always_comb begin
        state_nxt_s = state_r;
        mode_nxt_s  = mode_r;
        cnt_nxt_s   = cnt_r;
        res_a_nxt_s = Res_A;
        res_b_nxt_s = Res_B;
        c_a_nxt_s   = C_A;
        c_b_nxt_s   = C_B;
        done_nxt_s  = 1'b0;
        step_a_s    = shift_step(mode_r, Res_A, C_A);
        step_b_s    = shift_step(mode_r, Res_B, C_B);
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    res_a_nxt_s = A;
                    res_b_nxt_s = B;
                    mode_nxt_s  = Modo;
                    cnt_nxt_s   = Cantidad;
                    c_a_nxt_s   = 1'b0;
                    c_b_nxt_s   = 1'b0;
                    state_nxt_s = ST_SHIFT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (cnt_r != {AMT_W{1'b0}}) begin
                    {c_a_nxt_s, res_a_nxt_s} = step_a_s;
                    {c_b_nxt_s, res_b_nxt_s} = step_b_s;
                    cnt_nxt_s = cnt_r - AMT_W'(1);
                end else begin
                    state_nxt_s = ST_DONE;
                    done_nxt_s  = 1'b1;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
        busy_nxt_s = (state_nxt_s != ST_IDLE);
    end

    // State, working registers and registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            mode_r  <= 3'b000;
            cnt_r   <= {AMT_W{1'b0}};
            Res_A   <= {WIDTH{1'b0}};
            Res_B   <= {WIDTH{1'b0}};
            C_A     <= 1'b0;
            C_B     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            mode_r  <= mode_nxt_s;
            cnt_r   <= cnt_nxt_s;
            Res_A   <= res_a_nxt_s;
            Res_B   <= res_b_nxt_s;
            C_A     <= c_a_nxt_s;
            C_B     <= c_b_nxt_s;
            busy    <= busy_nxt_s;
            done    <= done_nxt_s;
        end
    end

endmodule

// File: tb/tb_shifter_iter.sv
// Directed self-checking bench for shifter_iter (WIDTH=8, AMT_W=3).
module tb_shifter_iter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [2:0] Modo = 3'b000;
    logic [7:0] A = 8'h00;
    logic [7:0] B = 8'h00;
    logic [2:0] Cantidad = 3'd0;
    logic       busy, done, C_A, C_B;
    logic [7:0] Res_A, Res_B;

    int n_cmp = 0;
    int n_bad = 0;

    shifter_iter #(.WIDTH(8), .AMT_W(3)) dut (
        .clk(clk), .rst(rst), .start(start), .Modo(Modo), .A(A), .B(B),
        .Cantidad(Cantidad), .busy(busy), .done(done), .Res_A(Res_A),
        .Res_B(Res_B), .C_A(C_A), .C_B(C_B)
    );

    always #5 clk = ~clk;

    // lat = cycles after accepting edge until done seen; inputs scrambled after acceptance
    task automatic run_op(input logic [2:0] m, input logic [7:0] a, input logic [7:0] b,
                          input logic [2:0] amt, output int lat, output int bcnt,
                          output logic busy_after);
        @(negedge clk);
        Modo = m; A = a; B = b; Cantidad = amt; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; A = ~a; B = ~b; Modo = 3'b101; Cantidad = ~amt;
        lat = -1;
        bcnt = 0;
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            if (busy) bcnt++;
            if (done) begin
                lat = j;
                break;
            end
        end
        @(negedge clk);
        busy_after = busy;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++;
        if ({busy, done, Res_A, Res_B, C_A, C_B} !== 20'h0) begin
            n_bad++;
            $display("FAIL reset_state got %05h want 00000", {busy, done, Res_A, Res_B, C_A, C_B});
        end
        rst = 1'b0;
    endtask

    task automatic test_sll();
        int lat, bcnt;
        logic ba;
        run_op(3'b000, 8'h96, 8'h81, 3'd3, lat, bcnt, ba);
        n_cmp++;
        if (lat !== 4) begin n_bad++; $display("FAIL sll_latency got %0d want 4", lat); end
        n_cmp++;
        if (bcnt !== 5) begin n_bad++; $display("FAIL sll_busy_cycles got %0d want 5", bcnt); end
        n_cmp++;
        if (ba !== 1'b0) begin n_bad++; $display("FAIL sll_busy_after got %b want 0", ba); end
        n_cmp++;
        if ({Res_A, Res_B, C_A, C_B} !== {8'hB0, 8'h08, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL sll_result got %h %h %b %b want b0 08 0 0", Res_A, Res_B, C_A, C_B);
        end
    endtask

    task automatic test_sra();
        int lat, bcnt;
        logic ba;
        run_op(3'b010, 8'h80, 8'h7F, 3'd7, lat, bcnt, ba);
        n_cmp++;
        if (lat !== 8) begin n_bad++; $display("FAIL sra_latency got %0d want 8", lat); end
        n_cmp++;
        if ({Res_A, Res_B, C_A, C_B} !== {8'hFF, 8'h00, 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL sra_result got %h %h %b %b want ff 00 0 1", Res_A, Res_B, C_A, C_B);
        end
    endtask

    task automatic test_rotate();
        int lat, bcnt;
        logic ba;
        run_op(3'b011, 8'hA5, 8'h0F, 3'd4, lat, bcnt, ba);
        n_cmp++;
        if ({Res_A, Res_B, C_A, C_B} !== {8'h5A, 8'hF0, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL rol_result got %h %h %b %b want 5a f0 0 0", Res_A, Res_B, C_A, C_B);
        end
        run_op(3'b100, 8'h01, 8'h02, 3'd1, lat, bcnt, ba);
        n_cmp++;
        if ({Res_A, Res_B, C_A, C_B} !== {8'h80, 8'h01, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL ror_result got %h %h %b %b want 80 01 1 0", Res_A, Res_B, C_A, C_B);
        end
    endtask

    task automatic test_zero_and_reserved();
        int lat, bcnt;
        logic ba;
        run_op(3'b000, 8'h3C, 8'hC3, 3'd0, lat, bcnt, ba);
        n_cmp++;
        if (lat !== 1) begin n_bad++; $display("FAIL zero_latency got %0d want 1", lat); end
        n_cmp++;
        if ({Res_A, Res_B, C_A} !== {8'h3C, 8'hC3, 1'b0}) begin
            n_bad++;
            $display("FAIL zero_result got %h %h %b want 3c c3 0", Res_A, Res_B, C_A);
        end
        run_op(3'b111, 8'h12, 8'h34, 3'd5, lat, bcnt, ba);
        n_cmp++;
        if (lat !== 6) begin n_bad++; $display("FAIL rsvd_latency got %0d want 6", lat); end
        n_cmp++;
        if ({Res_A, Res_B, C_A, C_B} !== {8'h12, 8'h34, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL rsvd_result got %h %h %b %b want 12 34 0 0", Res_A, Res_B, C_A, C_B);
        end
    endtask

    // First op SLL 2 of 11/22; start stays high (one low blip in SHIFT) so SRL 1 of AA/55 follows.
    task automatic test_back_to_back();
        @(negedge clk);
        Modo = 3'b000; A = 8'h11; B = 8'h22; Cantidad = 3'd2; start = 1'b1;
        @(posedge clk);
        #1;
        A = 8'hAA; B = 8'h55; Modo = 3'b001; Cantidad = 3'd1;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            start = (j == 1) ? 1'b0 : 1'b1;
            if (j == 3) begin
                n_cmp++;
                if ({done, Res_A, Res_B} !== {1'b1, 8'h44, 8'h88}) begin
                    n_bad++;
                    $display("FAIL b2b_first got %b %h %h want 1 44 88", done, Res_A, Res_B);
                end
            end else if (j == 4) begin
                n_cmp++;
                if ({busy, done, Res_A} !== {1'b0, 1'b0, 8'h44}) begin
                    n_bad++;
                    $display("FAIL b2b_idle_gap got %b %b %h want 0 0 44", busy, done, Res_A);
                end
            end else if (j == 5) begin
                start = 1'b0;
                n_cmp++;
                if ({busy, Res_A, Res_B} !== {1'b1, 8'hAA, 8'h55}) begin
                    n_bad++;
                    $display("FAIL b2b_second_load got %b %h %h want 1 aa 55", busy, Res_A, Res_B);
                end
            end else if (j == 7) begin
                start = 1'b0;
                n_cmp++;
                if ({done, Res_A, Res_B, C_A, C_B} !== {1'b1, 8'h55, 8'h2A, 1'b0, 1'b1}) begin
                    n_bad++;
                    $display("FAIL b2b_second_done got %b %h %h %b %b want 1 55 2a 0 1",
                             done, Res_A, Res_B, C_A, C_B);
                end
            end else if (j > 5) begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        int lat, bcnt;
        logic ba;
        @(negedge clk);
        Modo = 3'b000; A = 8'hFF; B = 8'h0F; Cantidad = 3'd6; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({busy, Res_A} !== {1'b1, 8'hFC}) begin
            n_bad++;
            $display("FAIL rst_mid_shift got %b %h want 1 fc", busy, Res_A);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({busy, done, Res_A, Res_B, C_A, C_B} !== 20'h0) begin
            n_bad++;
            $display("FAIL rst_async got %05h want 00000", {busy, done, Res_A, Res_B, C_A, C_B});
        end
        // start together with rst must be ignored
        start = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_beats_start got %b want 0", busy); end
        start = 1'b0;
        rst = 1'b0;
        run_op(3'b001, 8'hF0, 8'h0F, 3'd4, lat, bcnt, ba);
        n_cmp++;
        if ({lat[3:0], Res_A, Res_B, C_A, C_B} !== {4'd5, 8'h0F, 8'h00, 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL post_rst_srl got %0d %h %h %b %b want 5 0f 00 0 1",
                     lat, Res_A, Res_B, C_A, C_B);
        end
    endtask

    initial begin
        test_reset();
        test_sll();
        test_sra();
        test_rotate();
        test_zero_and_reserved();
        test_back_to_back();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
